// File: rtl/bcd_pkg.sv
// Shared constants and types for the digit-serial BCD adder.
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder: one decimal digit plus carry.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] da_i,
  input  logic [DIGIT_W-1:0] db_i,
  input  logic               c_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               carry_o
);

  logic [DIGIT_W:0] sumBin;

  // Binary add, then apply the +6 decimal correction whenever the total passes nine.
  always_comb begin
    sumBin  = {1'b0, da_i} + {1'b0, db_i} + {{DIGIT_W{1'b0}}, c_i};
    digit_o = sumBin[DIGIT_W-1:0];
    carry_o = 1'b0;
    if (sumBin > (DIGIT_W+1)'(BCD_MAX)) begin
      digit_o = sumBin[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
      carry_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder that sequences one shared digit adder over all digit
// positions, least-significant digit first, between two valid/ready handshakes.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                    ci,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                    co,
  output logic                    err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e                      state_q;
  logic [DIGIT_W*DIGITS-1:0]   a_q;
  logic [DIGIT_W*DIGITS-1:0]   b_q;
  logic [DIGIT_W*DIGITS-1:0]   sum_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        carry_q;
  logic                        co_q;
  logic                        err_q;
  logic                        inReady_q;
  logic                        outValid_q;

  logic                        err_d;
  logic [DIGIT_W-1:0]          digitA;
  logic [DIGIT_W-1:0]          digitB;
  logic [DIGIT_W-1:0]          digitSum;
  logic                        digitCarry;

  // Flag the operation if any incoming digit of either operand is not a decimal digit.
  always_comb begin
    err_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
          (b[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX))) begin
        err_d = 1'b1;
      end
    end
  end

  // Select the current digit position of both latched operands for the shared adder.
  always_comb begin
    digitA = a_q[idx_q*DIGIT_W +: DIGIT_W];
    digitB = b_q[idx_q*DIGIT_W +: DIGIT_W];
  end

  bcd_digit_add u_digit_add (
    .da_i    (digitA),
    .db_i    (digitB),
    .c_i     (carry_q),
    .digit_o (digitSum),
    .carry_o (digitCarry)
  );

  // Control FSM with registered handshake outputs and the operand/sum datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      co_q       <= 1'b0;
      err_q      <= 1'b0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          inReady_q <= 1'b1;
          if (in_valid && inReady_q) begin
            a_q       <= a;
            b_q       <= b;
            carry_q   <= ci;
            idx_q     <= '0;
            sum_q     <= '0;
            co_q      <= 1'b0;
            err_q     <= err_d;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q*DIGIT_W +: DIGIT_W] <= digitSum;
          carry_q <= digitCarry;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            co_q       <= digitCarry;
            outValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          inReady_q  <= 1'b0;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign sum       = sum_q;
  assign co        = co_q;
  assign err       = err_q;

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial multi-digit BCD adder. It accepts two packed DIGITS-digit BCD operands through a valid/ready handshake and adds them least-significant digit first, one digit per clock. A single shared single-digit BCD adder stage does the arithmetic, and the block presents the packed BCD sum and decimal carry-out through an output valid/ready handshake. It sits upstream of display and accumulation logic, wrapping the digit-level BCD add into a sequenced multi-digit operation.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits per operand (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand set presented
- in_ready  out  1  block can accept operands
- a  in  4*DIGITS  operand A, digit i at [4i+3:4i]
- b  in  4*DIGITS  operand B, same packing
- ci  in  1  decimal carry-in to digit 0
- out_valid  out  1  sum/co/err valid
- out_ready  in  1  consumer accepts result
- sum  out  4*DIGITS  packed BCD sum
- co  out  1  decimal carry-out of top digit
- err  out  1  at least one input digit of a or b was >9

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; carry←ci; idx←0; sum←0; err←(any digit of a or b >9). Go to RUN.
- RUN:
  - Each cycle, digit idx of A, digit idx of B and carry feed the digit adder.
  - sum digit idx←digit result; carry←digit carry; idx←idx+1.
  - When idx==DIGITS-1 that cycle: co←digit carry; go to DONE.
- DONE:
  - out_valid=1; sum/co/err held stable.
  - On out_ready: go to IDLE.
- Digit rule (per digit):
  - t = da+db+c as a 5-bit binary value.
  - If t>9: digit=(t+6) mod 16, carry=1. Otherwise digit=t, carry=0.
- Invalid digits (>9) are not rejected. The rule above is applied as-is and err flags the result.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored; operands are not sampled.
- idx width is clog2(DIGITS), minimum 1. Wrap is never reached because the transition out of RUN occurs at idx==DIGITS-1.

## Timing
- Reset (async, while rst_n=0): state=IDLE, in_ready=0, out_valid=0, sum=0, co=0, err=0, internal carry/idx=0.
- in_ready is registered. It rises at the first clk edge after rst_n release and thereafter equals (state==IDLE).
- Latency: acceptance at edge k → digits written at edges k+1…k+DIGITS → out_valid=1 in the cycle after edge k+DIGITS.
- Result handshake at edge m (out_valid&&out_ready): out_valid=0 and in_ready=1 after edge m.
- Earliest next acceptance is at edge m+1. Throughput is one operation per DIGITS+2 cycles with out_ready held high.
- out_valid, sum, co and err are registered outputs.
- sum digits above idx read 0 during RUN. Only DONE values are architecturally meaningful.
- Reset mid-RUN or mid-DONE: the operation is discarded, with no partial output. Reset values apply immediately.
- DIGITS=1: one RUN cycle, latency 1.

## Structure
- Package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=9, BCD_CORR=6.
  - State enum {IDLE, RUN, DONE}.
- Sub-module bcd_digit_add: combinational single-digit BCD adder (da, db, c → digit, carry) implementing the digit rule. One instance, shared across all digit positions via idx muxing.
- Top: FSM, operand/sum registers, idx counter, carry register, err detect.

## Test plan
All scenarios use DIGITS=4.
- a=0x1234, b=0x5678, ci=0 → sum=0x6912, co=0, err=0. out_valid rises 4 cycles after the accept edge.
- a=0x9999, b=0x0001, ci=0 → sum=0x0000, co=1 (full carry ripple through all digits).
- a=0x9999, b=0x9999, ci=1 → sum=0x9999, co=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → sum/co/err stable and in_ready=0. Toggling in_valid with new operands changes nothing. Next result accepts on out_ready=1.
- a=0x00A0, b=0x0000, ci=0 → err=1, sum=0x0100, co=0 (digit 1: t=10 → digit 0, carry 1).
- Assert rst_n=0 at the second RUN cycle → out_valid=0, sum=0 immediately. After release, in_ready=1 after one edge. A fresh 0x0005+0x0005 then yields 0x0010.
